// File: rtl/mm_pkg.sv
// mm_pkg
// Shared types and width helpers for the matrix-multiply job sequencer.
// The sequencer and its output FIFO both import this package.
//   - mm_state_e   : job sequencer state encoding
//   - clog2_min1   : ceil(log2(x)), never less than 1
//   - calc_*       : derived sizes, computed from the top-level parameters
package mm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_RUN    = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } mm_state_e;

  // An address or counter field always needs at least one bit, even when it
  // only ever holds the value 0.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int calc_a_beats(input int m, input int k, input int n_banks);
    return (m / n_banks) * k;
  endfunction

  function automatic int calc_b_beats(input int k, input int n, input int n_banks);
    return (k * n) / n_banks;
  endfunction

  function automatic int calc_c_words(input int m, input int n);
    return m * n;
  endfunction

  function automatic int calc_bidx_w(input int n_banks);
    return $clog2(n_banks);
  endfunction

  function automatic int calc_acc_width(input int data_width, input int k);
    return 2 * data_width + clog2_min1(k);
  endfunction

endpackage

// File: rtl/mm_out_skid_fifo.sv
// mm_out_skid_fifo
// Two-entry FIFO that decouples C-BRAM read latency from the result stream's
// backpressure. A push and a pop may happen in the same cycle, including
// when the FIFO is full.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (flushes the FIFO)
//   push       : write push_data this cycle
//   push_data  : word to store
//   pop        : remove the head this cycle (ignored while empty)
//   count      : number of stored words, 0..2
//   head       : oldest stored word
module mm_out_skid_fifo
  import mm_pkg::*;
#(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; reset clears the data too so the head
  // reads as zero after a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mm_job_sequencer.sv
// mm_job_sequencer
// Runs one complete matrix-multiply job on the `top` multiplier: streams A and
// B into the bank BRAMs, holds start_mult until mult_done, then reads C back
// and presents it as a valid/ready stream in row-major order.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   job_start / busy / job_done    : job control (start pulse, activity, done pulse)
//   ld_valid / ld_ready / ld_data  : load stream, one word per bank per beat
//   *_a_brams, *_b_brams           : BRAM port-A load interface of `top`
//   start_mult / mult_done         : multiplier handshake with `top`
//   read_en_c / read_addr_c/dout_c : C BRAM read port of `top` (1-cycle latency)
//   out_valid / out_ready/out_data : result stream
module mm_job_sequencer
  import mm_pkg::*;
#(
  parameter  int DATA_WIDTH   = 16,
  parameter  int M            = 3,
  parameter  int K            = 3,
  parameter  int N            = 3,
  parameter  int N_BANKS      = 3,
  localparam int A_BEATS      = calc_a_beats(M, K, N_BANKS),
  localparam int B_BEATS      = calc_b_beats(K, N, N_BANKS),
  localparam int C_WORDS      = calc_c_words(M, N),
  localparam int ABANK_W      = clog2_min1(A_BEATS),
  localparam int BBANK_W      = clog2_min1(B_BEATS),
  localparam int BIDX_W       = calc_bidx_w(N_BANKS),
  localparam int ADDR_WIDTH_A = BIDX_W + ABANK_W,
  localparam int ADDR_WIDTH_B = BIDX_W + BBANK_W,
  localparam int ADDR_WIDTH_C = clog2_min1(C_WORDS),
  localparam int ACC_WIDTH    = calc_acc_width(DATA_WIDTH, K)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            job_start,
  output logic                            busy,
  output logic                            job_done,
  input  logic                            ld_valid,
  output logic                            ld_ready,
  input  logic [N_BANKS*DATA_WIDTH-1:0]   ld_data,
  output logic                            en_a_brams,
  output logic                            we_a_brams,
  output logic [N_BANKS*ADDR_WIDTH_A-1:0] addr_a_brams,
  output logic [N_BANKS*DATA_WIDTH-1:0]   din_a_brams,
  output logic                            en_b_brams,
  output logic                            we_b_brams,
  output logic [N_BANKS*ADDR_WIDTH_B-1:0] addr_b_brams,
  output logic [N_BANKS*DATA_WIDTH-1:0]   din_b_brams,
  output logic                            start_mult,
  input  logic                            mult_done,
  output logic                            read_en_c,
  output logic [ADDR_WIDTH_C-1:0]         read_addr_c,
  input  logic [ACC_WIDTH-1:0]            dout_c,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ACC_WIDTH-1:0]            out_data
);

  // One beat counter serves both load phases, so it is sized for the larger.
  localparam int BEAT_W = (ABANK_W > BBANK_W) ? ABANK_W : BBANK_W;
  // The read counter must be able to hold C_WORDS itself (the "all issued" value).
  localparam int RD_W   = clog2_min1(C_WORDS + 1);

  localparam logic [BEAT_W-1:0] A_LAST = BEAT_W'(A_BEATS - 1);
  localparam logic [BEAT_W-1:0] B_LAST = BEAT_W'(B_BEATS - 1);
  localparam logic [RD_W-1:0]   C_CNT  = RD_W'(C_WORDS);

  mm_state_e        state;
  mm_state_e        next_state;
  logic [BEAT_W-1:0] beat_cnt;
  logic [RD_W-1:0]   rd_cnt;
  logic              inflight;
  logic              start_mult_q;

  logic              load_phase;
  logic              beat;
  logic              beat_last;
  logic [1:0]        fifo_count;
  logic [ACC_WIDTH-1:0] fifo_head;
  logic              fifo_pop;
  logic [2:0]        outstanding;
  logic              slot_free;
  logic              rd_issue;
  logic              drain_done;

  assign load_phase = (state == ST_LOAD_A) || (state == ST_LOAD_B);
  assign beat       = load_phase && ld_valid;
  assign beat_last  = (state == ST_LOAD_A) ? (beat_cnt == A_LAST) : (beat_cnt == B_LAST);

  // Reads in flight plus words already buffered may never exceed the two
  // FIFO slots. A pop in the same cycle frees a slot, which is what lets the
  // stream run at one word per cycle while out_ready stays high.
  assign fifo_pop    = out_valid && out_ready;
  assign outstanding = {1'b0, fifo_count} + {2'b00, inflight};
  assign slot_free   = (outstanding < 3'd2) || ((outstanding == 3'd2) && fifo_pop);
  assign rd_issue    = (state == ST_DRAIN) && (rd_cnt < C_CNT) && slot_free;
  assign drain_done  = (rd_cnt == C_CNT) && !inflight && (fifo_count == 2'd0);

  assign start_mult = start_mult_q;
  assign out_valid  = (fifo_count != 2'd0);
  assign out_data   = out_valid ? fifo_head : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (job_start) next_state = ST_LOAD_A;
      ST_LOAD_A: if (beat && beat_last) next_state = ST_LOAD_B;
      ST_LOAD_B: if (beat && beat_last) next_state = ST_RUN;
      ST_RUN:    if (mult_done) next_state = ST_WAIT;
      ST_WAIT:   next_state = ST_DRAIN;
      ST_DRAIN:  if (drain_done) next_state = ST_DONE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Counters, the C read-latency flag and the registered start_mult.
  // start_mult is computed from the current state, so it rises one cycle after
  // entering RUN and falls on the edge that samples mult_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt     <= '0;
      rd_cnt       <= '0;
      inflight     <= 1'b0;
      start_mult_q <= 1'b0;
    end else begin
      if (beat) begin
        beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
      end
      if (rd_issue) begin
        rd_cnt <= rd_cnt + 1'b1;
      end else if (state != ST_DRAIN) begin
        rd_cnt <= '0;
      end
      inflight     <= rd_issue;
      start_mult_q <= (state == ST_RUN) && !mult_done;
    end
  end

  // Output decode. Lane b of a load beat goes to bank b at offset beat_cnt.
  always_comb begin
    busy         = (state != ST_IDLE);
    job_done     = 1'b0;
    ld_ready     = 1'b0;
    en_a_brams   = 1'b0;
    we_a_brams   = 1'b0;
    addr_a_brams = '0;
    din_a_brams  = '0;
    en_b_brams   = 1'b0;
    we_b_brams   = 1'b0;
    addr_b_brams = '0;
    din_b_brams  = '0;
    read_en_c    = 1'b0;
    read_addr_c  = '0;
    case (state)
      ST_LOAD_A: begin
        ld_ready = 1'b1;
        if (beat) begin
          en_a_brams  = 1'b1;
          we_a_brams  = 1'b1;
          din_a_brams = ld_data;
          for (int b = 0; b < N_BANKS; b++) begin
            addr_a_brams[b*ADDR_WIDTH_A +: ADDR_WIDTH_A] = {BIDX_W'(b), beat_cnt[ABANK_W-1:0]};
          end
        end
      end
      ST_LOAD_B: begin
        ld_ready = 1'b1;
        if (beat) begin
          en_b_brams  = 1'b1;
          we_b_brams  = 1'b1;
          din_b_brams = ld_data;
          for (int b = 0; b < N_BANKS; b++) begin
            addr_b_brams[b*ADDR_WIDTH_B +: ADDR_WIDTH_B] = {BIDX_W'(b), beat_cnt[BBANK_W-1:0]};
          end
        end
      end
      ST_DRAIN: begin
        read_en_c = rd_issue;
        if (rd_issue) begin
          read_addr_c = rd_cnt[ADDR_WIDTH_C-1:0];
        end
      end
      ST_DONE: job_done = 1'b1;
      default: ;
    endcase
  end

  // C words land in the FIFO the cycle after their read was issued.
  mm_out_skid_fifo #(
    .WIDTH(ACC_WIDTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_data(dout_c),
    .pop      (fifo_pop),
    .count    (fifo_count),
    .head     (fifo_head)
  );

endmodule
